elevator_status_tx: RTL and testbench
=====================================

# elevator_status_tx

Serial status reporter for the cargo elevator. On a start pulse it snapshots the current floor and direction, then walks the elevator-content RAM from address 0. It emits a UART 8N1 frame on TX: a header byte, one byte per occupied slot, optionally a checksum, and a terminator. It sits downstream of the content RAM and the floor register, consuming the tipo/destino read port that is otherwise unused, and is the transmit counterpart of the existing 8N1 receiver.

## Interface
- CICLOS_BIT, 434: clock cycles per UART bit (50 MHz / 115200).
- N_ENTRADAS, 16: content RAM depth; must be ≤ 16.
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request; level-sampled only in IDLE.
- andar_atual  in  2  current floor.
- sobe  in  1  elevator direction (1 = up).
- ram_valido  in  1  slot at ram_addr is occupied; combinational read.
- ram_tipo  in  2  object type at ram_addr.
- ram_destino  in  2  object destination at ram_addr.
- ram_addr  out  4  content RAM read address.
- TX  out  1  serial line, idle high.
- ocupado  out  1  high from the cycle after iniciar is accepted until the terminator stop bit ends.
- pronto  out  1  one-cycle pulse after the terminator stop bit.
- db_estado  out  4  FSM state code, for debug.

## Operation
- FSM states (db_estado codes):
  - IDLE = 0
  - CARREGA = 1
  - START = 2
  - DADOS = 3
  - STOP = 4
  - FIM = 5
- IDLE:
  - TX = 1, ocupado = 0.
  - iniciar = 1 latches andar_atual and sobe into a snapshot, clears ram_addr and the checksum, sets phase = HEADER, and goes to CARREGA.
- CARREGA (1 cycle, TX = 1) loads the shift register according to phase:
  - HEADER: byte {4'hA, 1'b0, sobe_snap, andar_snap}. Next phase = ENTRADA.
  - ENTRADA with ram_valido = 1: byte {2'b01, ram_tipo, ram_destino, andar_snap}. ram_addr increments after the load.
  - ENTRADA with ram_valido = 0, or ram_addr reached N_ENTRADAS: the scan ends and this cycle loads the next phase's byte instead, with no extra cycle. That byte is the checksum if enabled, otherwise the terminator 0xFF.
  - TERMINADOR: byte 0xFF; after its STOP the FSM goes to FIM.
- START: TX = 0 for CICLOS_BIT cycles.
- DADOS: 8 bits, LSB first, each held CICLOS_BIT cycles.
- STOP: TX = 1 for CICLOS_BIT cycles, then CARREGA (or FIM after the terminator).
- FIM: pronto = 1 for one cycle, then IDLE.
- The scan stops at the first unoccupied slot, because the content RAM is compacted.
- ram_addr wrap is never reached: the scan stops at N_ENTRADAS before the 4-bit counter can wrap.

## Timing
- Reset values:
  - TX = 1, ocupado = 0, pronto = 0.
  - ram_addr = 0, db_estado = 0.
  - shift register, snapshot and checksum all 0.
- Reset asserted mid-frame forces TX high in the same instant (asynchronous) and returns the FSM to IDLE. No partial byte completes.
- Start latency: iniciar high at edge k → CARREGA at k+1 → TX falls at edge k+2.
- Each byte takes 1 + 10·CICLOS_BIT cycles, including the CARREGA cycle.
- Frame length = (bytes) · (1 + 10·CICLOS_BIT) + 1 (FIM) cycles.
- iniciar while ocupado is ignored and is not queued.
- ram_tipo, ram_destino and ram_valido are sampled only in the CARREGA cycle. The RAM may change at any other time.
- andar_atual and sobe are sampled only in the IDLE acceptance cycle.
- The bit counter uses ⌈log2(CICLOS_BIT)⌉ bits and reloads on every bit boundary.

## Configuration
- STATUS_TX_CHECKSUM_EN defined:
  - A running XOR accumulates over the header and every entry byte.
  - The XOR result is sent as one byte after the last entry, before the terminator 0xFF.
  - The terminator is excluded from the XOR.
- STATUS_TX_CHECKSUM_EN undefined: no checksum byte and no XOR register; the terminator follows the last entry directly.

## Test plan
All scenarios use CICLOS_BIT = 4.
1. Empty RAM, andar = 2, sobe = 1, pulse iniciar:
   - TX carries 0xA6 then 0xFF. With STATUS_TX_CHECKSUM_EN, 0xA6, 0xA6, 0xFF.
   - pronto pulses exactly once, at cycle 2·41 + 2 (or 3·41 + 2 with checksum) after iniciar.
2. Slots 0 and 1 valid, (tipo, destino) = (1, 3) and (2, 0); slot 2 invalid; andar = 1, sobe = 0:
   - Frame is 0xA1, 0x5D, 0x61, [checksum 0x9D], 0xFF.
   - ram_addr ends at 2.
3. All 16 slots valid:
   - 16 entry bytes, then the terminator.
   - ram_addr never exceeds 15 during the scan.
4. Pulse iniciar again while ocupado:
   - Frame is unchanged and no second frame follows.
   - andar_atual changes mid-frame do not alter later entry bytes.
5. Assert reset during DADOS of the second byte:
   - TX = 1, ocupado = 0, db_estado = 0 immediately.
   - A new iniciar after release produces a complete frame.
6. Bit timing check: start bit is low for exactly 4 cycles; data is LSB first; stop bit is high for 4 cycles; there is 1 idle-high cycle between consecutive bytes.

Source files
------------

// File: rtl/elevator_status_tx.sv
// UART 8N1 status reporter: header, one byte per occupied RAM slot, optional XOR checksum, 0xFF terminator.
// Optional feature: define STATUS_TX_CHECKSUM_EN to send the running XOR before the terminator.
module elevator_status_tx #(
    parameter int CICLOS_BIT = 434,
    parameter int N_ENTRADAS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [1:0] andar_atual,
    input  logic       sobe,
    input  logic       ram_valido,
    input  logic [1:0] ram_tipo,
    input  logic [1:0] ram_destino,
    output logic [3:0] ram_addr,
    output logic       TX,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int               CNT_W       = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_ULTIMO  = CNT_W'(CICLOS_BIT - 1);
    localparam logic [3:0]       ADDR_ULTIMO = 4'(N_ENTRADAS - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CARREGA = 4'd1,
        START   = 4'd2,
        DADOS   = 4'd3,
        STOP    = 4'd4,
        FIM     = 4'd5
    } estado_t;

    typedef enum logic [1:0] {
        F_HEADER,
        F_ENTRADA,
        F_TERMINADOR,
        F_CONCLUIDO
    } fase_t;

    estado_t          r_estado;
    estado_t          w_prox;
    fase_t            r_fase;
    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_ciclo;
    logic [2:0]       r_bit;
    logic [3:0]       r_addr;
    logic             r_scan_cheio;
    logic [1:0]       r_andar_snap;
    logic             r_sobe_snap;
    logic             r_tx;
    logic             r_pronto;
    logic             w_fim_bit;
    logic             w_tx_prox;
    logic [7:0]       w_byte_header;
    logic [7:0]       w_byte_entrada;
    logic [7:0]       w_byte_pos_scan;
    fase_t            w_fase_pos_scan;

`ifdef STATUS_TX_CHECKSUM_EN
    logic [7:0] r_chk;
    assign w_byte_pos_scan = r_chk;
    assign w_fase_pos_scan = F_TERMINADOR;
`else
    assign w_byte_pos_scan = 8'hFF;
    assign w_fase_pos_scan = F_CONCLUIDO;
`endif

    assign w_fim_bit      = (r_ciclo == CNT_ULTIMO);
    assign w_byte_header  = {4'hA, 1'b0, r_sobe_snap, r_andar_snap};
    assign w_byte_entrada = {2'b01, ram_tipo, ram_destino, r_andar_snap};

    assign ram_addr  = r_addr;
    assign TX        = r_tx;
    assign pronto    = r_pronto;
    assign db_estado = r_estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            IDLE:    if (iniciar) w_prox = CARREGA;
            CARREGA: w_prox = START;
            START:   if (w_fim_bit) w_prox = DADOS;
            DADOS:   if (w_fim_bit && (r_bit == 3'd7)) w_prox = STOP;
            STOP:    if (w_fim_bit) w_prox = (r_fase == F_CONCLUIDO) ? FIM : CARREGA;
            FIM:     w_prox = IDLE;
            default: w_prox = IDLE;
        endcase
    end

    // The line is re-registered one cycle behind the state so TX is glitch-free and resets high asynchronously.
    always_comb begin
        w_tx_prox = 1'b1;
        ocupado   = (r_estado != IDLE);
        case (r_estado)
            START:   w_tx_prox = 1'b0;
            DADOS:   w_tx_prox = r_shift[0];
            default: w_tx_prox = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx         <= 1'b1;
            r_pronto     <= 1'b0;
            r_fase       <= F_HEADER;
            r_shift      <= 8'h00;
            r_ciclo      <= '0;
            r_bit        <= 3'd0;
            r_addr       <= 4'd0;
            r_scan_cheio <= 1'b0;
            r_andar_snap <= 2'd0;
            r_sobe_snap  <= 1'b0;
`ifdef STATUS_TX_CHECKSUM_EN
            r_chk        <= 8'h00;
`endif
        end else begin
            r_tx     <= w_tx_prox;
            r_pronto <= (r_estado == FIM);
            case (r_estado)
                IDLE: begin
                    if (iniciar) begin
                        r_andar_snap <= andar_atual;
                        r_sobe_snap  <= sobe;
                        r_addr       <= 4'd0;
                        r_scan_cheio <= 1'b0;
                        r_fase       <= F_HEADER;
`ifdef STATUS_TX_CHECKSUM_EN
                        r_chk        <= 8'h00;
`endif
                    end
                end
                CARREGA: begin
                    r_ciclo <= '0;
                    r_bit   <= 3'd0;
                    case (r_fase)
                        F_HEADER: begin
                            r_shift <= w_byte_header;
                            r_fase  <= F_ENTRADA;
`ifdef STATUS_TX_CHECKSUM_EN
                            r_chk   <= r_chk ^ w_byte_header;
`endif
                        end
                        F_ENTRADA: begin
                            // Last slot holds the address at N-1 instead of wrapping; a flag ends the scan.
                            if (ram_valido && !r_scan_cheio) begin
                                r_shift <= w_byte_entrada;
`ifdef STATUS_TX_CHECKSUM_EN
                                r_chk   <= r_chk ^ w_byte_entrada;
`endif
                                if (r_addr == ADDR_ULTIMO) begin
                                    r_scan_cheio <= 1'b1;
                                end else begin
                                    r_addr <= r_addr + 4'd1;
                                end
                            end else begin
                                r_shift <= w_byte_pos_scan;
                                r_fase  <= w_fase_pos_scan;
                            end
                        end
                        F_TERMINADOR: begin
                            r_shift <= 8'hFF;
                            r_fase  <= F_CONCLUIDO;
                        end
                        default: r_shift <= 8'hFF;
                    endcase
                end
                START, STOP: begin
                    r_ciclo <= w_fim_bit ? '0 : r_ciclo + CNT_W'(1);
                end
                DADOS: begin
                    if (w_fim_bit) begin
                        r_ciclo <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_ciclo <= r_ciclo + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_status_tx.sv
// Randomized self-checking bench for elevator_status_tx with CICLOS_BIT = 4.
// A high-level frame model and a UART line decoder provide all expected values.
module tb_elevator_status_tx;

    localparam int CB        = 4;
    localparam int BYTE_CYC  = 1 + 10 * CB;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [1:0] andar_atual;
    logic       sobe;
    logic       ram_valido;
    logic [1:0] ram_tipo;
    logic [1:0] ram_destino;
    logic [3:0] ram_addr;
    logic       TX;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic       ram_v [16];
    logic [1:0] ram_t [16];
    logic [1:0] ram_d [16];

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] cap_bytes[$];
    logic       tx_samples[$];
    int exp_addr;
    int cap_pronto_idx, cap_pronto_cnt, cap_bad, cap_first_start, cap_final_addr, cap_addr_back;

    elevator_status_tx #(.CICLOS_BIT(CB), .N_ENTRADAS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .andar_atual(andar_atual),
        .sobe       (sobe),
        .ram_valido (ram_valido),
        .ram_tipo   (ram_tipo),
        .ram_destino(ram_destino),
        .ram_addr   (ram_addr),
        .TX         (TX),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign ram_valido  = ram_v[ram_addr];
    assign ram_tipo    = ram_t[ram_addr];
    assign ram_destino = ram_d[ram_addr];

    // Compacted RAM: the first n slots are occupied with random contents, the rest empty with junk.
    task automatic fill_ram(input int n);
        for (int a = 0; a < 16; a++) begin
            ram_v[a] = (a < n);
            ram_t[a] = 2'($urandom_range(0, 3));
            ram_d[a] = 2'($urandom_range(0, 3));
        end
    endtask

    // Reference frame built straight from the byte layout rules.
    function automatic void build_expected(input int andar, input int sb);
        int chk, n, b;
        exp_bytes.delete();
        b   = 160 + sb * 4 + andar;
        chk = b;
        exp_bytes.push_back(8'(b));
        n = 0;
        while (n < 16 && ram_v[n] == 1'b1) begin
            b   = 64 + int'(ram_t[n]) * 16 + int'(ram_d[n]) * 4 + andar;
            chk = chk ^ b;
            exp_bytes.push_back(8'(b));
            n++;
        end
`ifdef STATUS_TX_CHECKSUM_EN
        exp_bytes.push_back(8'(chk));
`endif
        exp_bytes.push_back(8'hFF);
        exp_addr = (n == 16) ? 15 : n;
    endfunction

    // Turns the per-cycle TX samples into bytes, counting any framing or spacing violation.
    function automatic void decode_line();
        int i, prev;
        logic ok, v;
        logic [7:0] val;
        cap_bytes.delete();
        cap_bad = 0;
        cap_first_start = -1;
        prev = -1;
        i = 1;
        while (i < tx_samples.size()) begin
            if (tx_samples[i] === 1'b0) begin
                if (i + 40 > tx_samples.size()) begin
                    cap_bad++;
                    break;
                end
                ok = 1'b1;
                for (int j = 0; j < CB; j++) if (tx_samples[i + j] !== 1'b0) ok = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    v = tx_samples[i + CB + CB * b];
                    for (int j = 0; j < CB; j++) if (tx_samples[i + CB + CB * b + j] !== v) ok = 1'b0;
                    val[b] = v;
                end
                for (int j = 9 * CB; j < 10 * CB; j++) if (tx_samples[i + j] !== 1'b1) ok = 1'b0;
                if (prev >= 0 && (i - prev) != BYTE_CYC) ok = 1'b0;
                if (prev < 0) cap_first_start = i;
                if (!ok) cap_bad++;
                cap_bytes.push_back(val);
                prev = i;
                i = i + 10 * CB;
            end else begin
                i++;
            end
        end
    endfunction

    // Pulses iniciar and records the line until well after pronto; busy_at > 0 re-pulses iniciar mid-frame.
    task automatic capture_frame(input logic [1:0] andar, input logic sb, input int busy_at);
        int last_addr;
        @(negedge clock);
        tx_samples.delete();
        tx_samples.push_back(TX);
        cap_pronto_idx = -1;
        cap_pronto_cnt = 0;
        cap_addr_back  = 0;
        last_addr      = 0;
        andar_atual = andar;
        sobe        = sb;
        iniciar     = 1'b1;
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clock);
            tx_samples.push_back(TX);
            if (pronto === 1'b1) begin
                cap_pronto_cnt++;
                if (cap_pronto_idx < 0) cap_pronto_idx = c;
            end
            if (c >= 2 && int'(ram_addr) < last_addr) cap_addr_back++;
            last_addr = int'(ram_addr);
            iniciar = (busy_at > 0 && c == busy_at);
            if (c == busy_at) begin
                andar_atual = ~andar;
                sobe        = ~sb;
            end
            if (cap_pronto_idx >= 0 && c >= cap_pronto_idx + 60) break;
        end
        iniciar = 1'b0;
        cap_final_addr = int'(ram_addr);
        decode_line();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        iniciar = 1'b0;
        andar_atual = 2'd0;
        sobe = 1'b0;
        fill_ram(0);
        repeat (3) @(negedge clock);
        checks++; if (TX !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx got %b want 1", TX); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL reset_ocupado got %b want 0", ocupado); end
        checks++; if (pronto !== 1'b0) begin errors++; $display("[TB] FAIL reset_pronto got %b want 0", pronto); end
        checks++; if (ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", ram_addr); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("[TB] FAIL reset_estado got %0d want 0", db_estado); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (TX !== 1'b1) begin errors++; $display("[TB] FAIL idle_tx got %b want 1", TX); end
    endtask

    task automatic test_empty_ram();
        fill_ram(0);
        capture_frame(2'd2, 1'b1, 0);
        build_expected(2, 1);
        checks++;
        if (cap_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("[TB] FAIL empty_len got %0d want %0d", cap_bytes.size(), exp_bytes.size());
        end else begin
            foreach (exp_bytes[i]) begin
                checks++;
                if (cap_bytes[i] !== exp_bytes[i]) begin errors++; $display("[TB] FAIL empty_byte%0d got %h want %h", i, cap_bytes[i], exp_bytes[i]); end
            end
            checks++; if (cap_bytes[0] !== 8'hA6) begin errors++; $display("[TB] FAIL empty_header got %h want a6", cap_bytes[0]); end
        end
        checks++; if (cap_pronto_idx !== exp_bytes.size() * BYTE_CYC + 2) begin errors++; $display("[TB] FAIL empty_pronto_time got %0d want %0d", cap_pronto_idx, exp_bytes.size() * BYTE_CYC + 2); end
        checks++; if (cap_pronto_cnt !== 1) begin errors++; $display("[TB] FAIL empty_pronto_count got %0d want 1", cap_pronto_cnt); end
        checks++; if (cap_first_start !== 3) begin errors++; $display("[TB] FAIL start_latency got %0d want 3", cap_first_start); end
        checks++; if (cap_bad !== 0) begin errors++; $display("[TB] FAIL empty_bit_timing got %0d violations want 0", cap_bad); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL empty_ocupado_after got %b want 0", ocupado); end
    endtask

    task automatic test_two_entries();
        logic [7:0] want[$];
        fill_ram(2);
        ram_t[0] = 2'd1; ram_d[0] = 2'd3;
        ram_t[1] = 2'd2; ram_d[1] = 2'd0;
        want.push_back(8'hA1);
        want.push_back(8'h5D);
        want.push_back(8'h61);
`ifdef STATUS_TX_CHECKSUM_EN
        want.push_back(8'h9D);
`endif
        want.push_back(8'hFF);
        capture_frame(2'd1, 1'b0, 0);
        checks++;
        if (cap_bytes.size() !== want.size()) begin
            errors++; $display("[TB] FAIL two_len got %0d want %0d", cap_bytes.size(), want.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (cap_bytes[i] !== want[i]) begin errors++; $display("[TB] FAIL two_byte%0d got %h want %h", i, cap_bytes[i], want[i]); end
            end
        end
        checks++; if (cap_final_addr !== 2) begin errors++; $display("[TB] FAIL two_final_addr got %0d want 2", cap_final_addr); end
        checks++; if (cap_bad !== 0) begin errors++; $display("[TB] FAIL two_bit_timing got %0d violations want 0", cap_bad); end
    endtask

    task automatic test_full_ram();
        fill_ram(16);
        capture_frame(2'd3, 1'b1, 0);
        build_expected(3, 1);
        checks++;
        if (cap_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("[TB] FAIL full_len got %0d want %0d", cap_bytes.size(), exp_bytes.size());
        end else begin
            foreach (exp_bytes[i]) begin
                checks++;
                if (cap_bytes[i] !== exp_bytes[i]) begin errors++; $display("[TB] FAIL full_byte%0d got %h want %h", i, cap_bytes[i], exp_bytes[i]); end
            end
        end
        checks++; if (cap_final_addr !== exp_addr) begin errors++; $display("[TB] FAIL full_final_addr got %0d want %0d", cap_final_addr, exp_addr); end
        checks++; if (cap_addr_back !== 0) begin errors++; $display("[TB] FAIL full_addr_wrap got %0d decreases want 0", cap_addr_back); end
        checks++; if (cap_pronto_idx !== exp_bytes.size() * BYTE_CYC + 2) begin errors++; $display("[TB] FAIL full_pronto_time got %0d want %0d", cap_pronto_idx, exp_bytes.size() * BYTE_CYC + 2); end
        checks++; if (cap_bad !== 0) begin errors++; $display("[TB] FAIL full_bit_timing got %0d violations want 0", cap_bad); end
    endtask

    task automatic test_busy_ignore();
        fill_ram(3);
        capture_frame(2'd1, 1'b1, 20);
        build_expected(1, 1);
        checks++;
        if (cap_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("[TB] FAIL busy_len got %0d want %0d", cap_bytes.size(), exp_bytes.size());
        end else begin
            foreach (exp_bytes[i]) begin
                checks++;
                if (cap_bytes[i] !== exp_bytes[i]) begin errors++; $display("[TB] FAIL busy_byte%0d got %h want %h", i, cap_bytes[i], exp_bytes[i]); end
            end
        end
        checks++; if (cap_pronto_cnt !== 1) begin errors++; $display("[TB] FAIL busy_pronto_count got %0d want 1", cap_pronto_cnt); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("[TB] FAIL busy_final_estado got %0d want 0", db_estado); end
    endtask

    task automatic test_reset_mid_frame();
        fill_ram(2);
        @(negedge clock);
        andar_atual = 2'd3;
        sobe = 1'b0;
        iniciar = 1'b1;
        for (int c = 1; c <= 61; c++) begin
            @(negedge clock);
            iniciar = 1'b0;
        end
        checks++; if (db_estado !== 4'd3) begin errors++; $display("[TB] FAIL mid_estado got %0d want 3", db_estado); end
        reset = 1'b0;
        #1;
        checks++; if (TX !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_tx got %b want 1", TX); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ocupado got %b want 0", ocupado); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_estado got %0d want 0", db_estado); end
        checks++; if (ram_addr !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_addr got %0d want 0", ram_addr); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (TX !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_idle got %b want 1", TX); end
        capture_frame(2'd0, 1'b1, 0);
        build_expected(0, 1);
        checks++;
        if (cap_bytes.size() !== exp_bytes.size()) begin
            errors++; $display("[TB] FAIL after_reset_len got %0d want %0d", cap_bytes.size(), exp_bytes.size());
        end else begin
            foreach (exp_bytes[i]) begin
                checks++;
                if (cap_bytes[i] !== exp_bytes[i]) begin errors++; $display("[TB] FAIL after_reset_byte%0d got %h want %h", i, cap_bytes[i], exp_bytes[i]); end
            end
        end
        checks++; if (cap_pronto_cnt !== 1) begin errors++; $display("[TB] FAIL after_reset_pronto got %0d want 1", cap_pronto_cnt); end
    endtask

    task automatic test_random();
        int n, an, sb;
        for (int it = 0; it < 5; it++) begin
            n  = $urandom_range(0, 16);
            an = $urandom_range(0, 3);
            sb = $urandom_range(0, 1);
            fill_ram(n);
            capture_frame(2'(an), 1'(sb), 0);
            build_expected(an, sb);
            checks++;
            if (cap_bytes.size() !== exp_bytes.size()) begin
                errors++; $display("[TB] FAIL rand%0d_len got %0d want %0d", it, cap_bytes.size(), exp_bytes.size());
            end else begin
                foreach (exp_bytes[i]) begin
                    checks++;
                    if (cap_bytes[i] !== exp_bytes[i]) begin errors++; $display("[TB] FAIL rand%0d_byte%0d got %h want %h", it, i, cap_bytes[i], exp_bytes[i]); end
                end
            end
            checks++; if (cap_pronto_idx !== exp_bytes.size() * BYTE_CYC + 2) begin errors++; $display("[TB] FAIL rand%0d_pronto_time got %0d want %0d", it, cap_pronto_idx, exp_bytes.size() * BYTE_CYC + 2); end
            checks++; if (cap_final_addr !== exp_addr) begin errors++; $display("[TB] FAIL rand%0d_final_addr got %0d want %0d", it, cap_final_addr, exp_addr); end
            checks++; if (cap_bad !== 0) begin errors++; $display("[TB] FAIL rand%0d_bit_timing got %0d violations want 0", it, cap_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_empty_ram();
        test_two_entries();
        test_full_ram();
        test_busy_ignore();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
